cla16_seq_arbiter: RTL



---
 rtl/cla16_seq_arbiter_pkg.sv | 22 ++
 rtl/cla16_seq_arbiter_rr_arb2.sv | 46 ++++
 rtl/four_bit_cla.sv | 32 +++
 rtl/cla16_seq_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cla16_seq_arbiter_pkg.sv
// Shared definitions for the sequential CLA adder with two-way arbitration.
//   state_t     : sequencing FSM states (IDLE, RUN, DONE)
//   SLICE_W     : width of the shared carry-lookahead slice
//   beat_cnt_w  : beat counter width for a given beat count (never below 1)
package cla16_seq_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    function automatic int beat_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Beat counter width for the default 16-bit configuration.
    localparam int BEAT_W = beat_cnt_w(16 / SLICE_W);

endpackage

// File: rtl/cla16_seq_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   valid[1:0] : requests
//   enable     : arbitration allowed this cycle (grant forced to 0 otherwise)
//   advance    : a grant is being consumed; the pointer moves past the winner
//   grant[1:0] : one-hot grant, combinational from valid and the pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       enable,
    input  logic       advance,
    output logic [1:0] grant
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                grant = rr_ptr_q ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
    end

    // After serving requester 0 favour 1, and vice versa.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = grant[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/four_bit_cla.sv
// Four-bit carry-lookahead adder slice.
//   a, b  : 4-bit operands
//   cin   : carry into bit 0
//   sum   : a + b + cin, low 4 bits
//   gOut  : group generate (slice produces a carry regardless of cin)
//   pOut  : group propagate (slice passes cin through to its carry-out)
module four_bit_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       gOut,
    output logic       pOut
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c;
    assign gOut = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign pOut = &p;

endmodule

// File: rtl/cla16_seq_arbiter.sv
// Multi-cycle WIDTH-bit adder built from one shared 4-bit CLA slice, shared
// between two requesters by a round-robin arbiter.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   reqN_valid/ready/a/b/cin       : operation request from requester N
//   res_valid/ready                : result handshake
//   res_id, res_sum, res_cout      : result tag, sum, carry-out
//   busy                           : an operation is in progress or pending
//
// state | meaning
// IDLE  | waiting for a request; ready = grant
// RUN   | one nibble per edge, LS nibble first
// DONE  | result presented until res_ready
module cla16_seq_arbiter
    import cla16_seq_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy
);

    localparam int BEATS = WIDTH / SLICE_W;
    localparam int BW    = beat_cnt_w(BEATS);

    state_t           state_q, state_d;
    logic [BW-1:0]    beat_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             res_id_q, res_cout_q;

    logic [1:0]         grant;
    logic               arb_en;
    logic               accept;
    logic               last_beat;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_g, slice_p;
    logic               carry_nxt;
    logic [WIDTH-1:0]   slice_ext;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   ({req1_valid, req0_valid}),
        .enable  (arb_en),
        .advance (accept),
        .grant   (grant)
    );

    // Operands shift right each beat, so the slice always reads the low nibble.
    four_bit_cla u_slice (
        .a    (a_q[SLICE_W-1:0]),
        .b    (b_q[SLICE_W-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .gOut (slice_g),
        .pOut (slice_p)
    );

    assign carry_nxt = slice_g | (slice_p & carry_q);
    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign accept    = |grant;
    // Each slice result enters at the top; after BEATS shifts nibble 0 is at the bottom.
    assign slice_ext = WIDTH'(slice_sum) << (WIDTH - SLICE_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_RUN;
            ST_RUN:  if (last_beat) state_d = ST_DONE;
            ST_DONE: if (res_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Arbitration is held off during reset so ready reads 0 while rst_n is low.
    always_comb begin
        arb_en    = (state_q == ST_IDLE) && rst_n;
        busy      = (state_q != ST_IDLE);
        res_valid = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            beat_q     <= '0;
            res_id_q   <= 1'b0;
            res_cout_q <= 1'b0;
        end else if (accept) begin
            a_q      <= grant[1] ? req1_a   : req0_a;
            b_q      <= grant[1] ? req1_b   : req0_b;
            carry_q  <= grant[1] ? req1_cin : req0_cin;
            res_id_q <= grant[1];
            beat_q   <= '0;
        end else if (state_q == ST_RUN) begin
            a_q     <= a_q >> SLICE_W;
            b_q     <= b_q >> SLICE_W;
            sum_q   <= (sum_q >> SLICE_W) | slice_ext;
            carry_q <= carry_nxt;
            beat_q  <= beat_q + BW'(1);
            if (last_beat) begin
                res_cout_q <= carry_nxt;
            end
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign res_id     = res_id_q;
    assign res_sum    = sum_q;
    assign res_cout   = res_cout_q;

endmodule
